// File: rtl/sram_mem_stage.sv
// sram_mem_stage: memory-stage data-memory controller.
// Each 32-bit load/store from the EX/MEM register becomes two 16-bit
// accesses on an external asynchronous SRAM: low half first, then high half.
// Each half lasts WAIT_CYCLES clocks. The pipeline is frozen while ready is low.
//
// Handshake: a request (Mem_R_EN / Mem_W_EN) is sampled while the FSM is
// IDLE, and it pulls ready low in that same cycle. The request must stay
// stable until the cycle in which ready is high again (DONE). The pipeline
// advances on the clock edge that ends the DONE cycle. A store wins over a
// load when both are asserted.
module sram_mem_stage #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_R_EN,
  input  logic        Mem_W_EN,
  input  logic [31:0] ALU_res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] mem_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic [2:0]  dbg_state,
  output logic        dbg_dq_oe
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [16:0]       word_idx;
  logic [15:0]       wr_hi;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic [31:0]       offset;
  logic              last;
  logic              unused_offset_bits;

  // Byte offset into the SRAM window; bits [18:2] select the 32-bit word.
  assign offset = ALU_res - 32'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Final cycle of the current half-word phase.
  assign last = (cnt == CNT_LAST);

  // Pipeline may advance when idle with no request, or in the DONE cycle.
  assign ready = ((state == IDLE) && !Mem_R_EN && !Mem_W_EN) || (state == DONE);

  // The data bus is driven only during write phases.
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign dbg_state = state;
  assign dbg_dq_oe = dq_oe;

  // Access sequencer. SRAM address, write strobe and bus drive are registered,
  // so they are set up on the edge that enters each phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_idx  <= '0;
      wr_hi     <= '0;
      mem_data  <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (Mem_W_EN) begin
            word_idx  <= offset[18:2];
            wr_hi     <= Val_Rm[31:16];
            SRAM_ADDR <= {offset[18:2], 1'b0};
            SRAM_WE_N <= 1'b0;
            dq_oe     <= 1'b1;
            dq_out    <= Val_Rm[15:0];
            state     <= WR_LO;
          end else if (Mem_R_EN) begin
            word_idx  <= offset[18:2];
            SRAM_ADDR <= {offset[18:2], 1'b0};
            state     <= RD_LO;
          end
        end
        RD_LO: begin
          if (last) begin
            mem_data[15:0] <= SRAM_DQ;
            SRAM_ADDR      <= {word_idx, 1'b1};
            cnt            <= '0;
            state          <= RD_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_HI: begin
          if (last) begin
            mem_data[31:16] <= SRAM_DQ;
            cnt             <= '0;
            state           <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_LO: begin
          if (last) begin
            SRAM_ADDR <= {word_idx, 1'b1};
            dq_out    <= wr_hi;
            cnt       <= '0;
            state     <= WR_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_HI: begin
          if (last) begin
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// tb_sram_mem_stage: directed bench for sram_mem_stage. Instance a uses
// WAIT_CYCLES=3 and instance b uses WAIT_CYCLES=1. Each instance has its
// own behavioural asynchronous SRAM model.
module tb_sram_mem_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT a (WAIT_CYCLES=3) ----------------
  logic        a_r, a_w;
  logic [31:0] a_alu, a_val, a_md;
  logic        a_ready, a_we_n, a_oe;
  logic [17:0] a_addr;
  logic [2:0]  a_state;
  wire  [15:0] dq_a;

  sram_mem_stage #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) dut_a (
    .clk(clk), .rst(rst), .Mem_R_EN(a_r), .Mem_W_EN(a_w),
    .ALU_res(a_alu), .Val_Rm(a_val), .mem_data(a_md), .ready(a_ready),
    .SRAM_ADDR(a_addr), .SRAM_DQ(dq_a), .SRAM_WE_N(a_we_n),
    .dbg_state(a_state), .dbg_dq_oe(a_oe)
  );

  // ---------------- DUT b (WAIT_CYCLES=1) ----------------
  logic        b_r, b_w;
  logic [31:0] b_alu, b_val, b_md;
  logic        b_ready, b_we_n, b_oe;
  logic [17:0] b_addr;
  logic [2:0]  b_state;
  wire  [15:0] dq_b;

  sram_mem_stage #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut_b (
    .clk(clk), .rst(rst), .Mem_R_EN(b_r), .Mem_W_EN(b_w),
    .ALU_res(b_alu), .Val_Rm(b_val), .mem_data(b_md), .ready(b_ready),
    .SRAM_ADDR(b_addr), .SRAM_DQ(dq_b), .SRAM_WE_N(b_we_n),
    .dbg_state(b_state), .dbg_dq_oe(b_oe)
  );

  // ---------------- SRAM models ----------------
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        pl_en, pl_sel;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  assign dq_a = a_we_n ? mem_a[a_addr[7:0]] : 16'hzzzz;
  assign dq_b = b_we_n ? mem_b[b_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!a_we_n) mem_a[a_addr[7:0]] <= dq_a;
    else if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
  end

  always @(posedge clk) begin
    if (!b_we_n) mem_b[b_addr[7:0]] <= dq_b;
    else if (pl_en && pl_sel) mem_b[pl_addr] <= pl_data;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check(tag, got, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  logic [17:0] lg_addr [0:31];
  logic        lg_we_n [0:31];
  logic        lg_oe   [0:31];
  logic [15:0] lg_dq   [0:31];
  int          lg_n;
  logic [31:0] done_md;

  task automatic preload(input logic sel, input logic [7:0] addr, input logic [15:0] data);
    pl_en = 1'b1; pl_sel = sel; pl_addr = addr; pl_data = data;
    @(posedge clk); #2;
    pl_en = 1'b0;
  endtask

  // Enter at posedge+2 with dut_a idle. Holds the request until ready
  // returns and logs bus signals at posedge+3 of every cycle.
  task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    a_r = rd; a_w = wr; a_alu = addr; a_val = wdata;
    lg_n = -1;
    done_md = 32'd0;
    #1;
    for (int i = 0; i < 32; i++) begin
      lg_addr[i] = a_addr; lg_we_n[i] = a_we_n; lg_oe[i] = a_oe; lg_dq[i] = dq_a;
      if (a_ready) begin
        lg_n = i;
        done_md = a_md;
        break;
      end
      @(posedge clk); #3;
    end
    a_r = 1'b0; a_w = 1'b0;
    check("access_done", 32'(lg_n >= 0), 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic check_phase(input string tag, input int first, input logic [17:0] addr,
                             input logic we_n, input logic chk_dq, input logic [15:0] dq);
    for (int i = first; i < first + 3; i++) begin
      check({tag, "_addr"}, 32'(lg_addr[i]), 32'(addr));
      check({tag, "_we_n"}, 32'(lg_we_n[i]), 32'(we_n));
      check({tag, "_oe"}, 32'(lg_oe[i]), 32'(!we_n));
      if (chk_dq) check({tag, "_dq"}, 32'(lg_dq[i]), 32'(dq));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rdy_b;
  logic [2:0] st_b4;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    a_r = 0; a_w = 0; a_alu = 0; a_val = 0;
    b_r = 0; b_w = 0; b_alu = 0; b_val = 0;
    pl_en = 0; pl_sel = 0; pl_addr = 0; pl_data = 0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_md", a_md, 32'd0);
    check("rst_we_n", 32'(a_we_n), 32'd1);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_oe", 32'(a_oe), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;

    // No request for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #3;
      check("idle_ready", 32'(a_ready), 32'd1);
      check("idle_we_n", 32'(a_we_n), 32'd1);
      check("idle_oe", 32'(a_oe), 32'd0);
    end
    @(posedge clk); #2;

    preload(1'b0, 8'd4, 16'hBEEF);
    preload(1'b0, 8'd5, 16'hDEAD);
    preload(1'b1, 8'd0, 16'h1111);
    preload(1'b1, 8'd1, 16'h2222);
    preload(1'b1, 8'd2, 16'h3333);
    preload(1'b1, 8'd3, 16'h4444);

    // Load from 1024+8: half-words 4 and 5.
    exp_q.push_back(32'hDEADBEEF);
    access_a(1'b1, 1'b0, 32'd1032, 32'd0);
    check("ld1_lat", 32'(lg_n), 32'd7);
    check_phase("ld1_lo", 1, 18'd4, 1'b1, 1'b0, 16'h0);
    check_phase("ld1_hi", 4, 18'd5, 1'b1, 1'b0, 16'h0);
    sb_check("ld1_data", done_md);

    // Store 0x12345678 to 1024+12: half-words 6 and 7.
    access_a(1'b0, 1'b1, 32'd1036, 32'h12345678);
    check("st1_lat", 32'(lg_n), 32'd7);
    check_phase("st1_lo", 1, 18'd6, 1'b0, 1'b1, 16'h5678);
    check_phase("st1_hi", 4, 18'd7, 1'b0, 1'b1, 16'h1234);
    check("st1_done_we_n", 32'(lg_we_n[7]), 32'd1);
    check("st1_done_oe", 32'(lg_oe[7]), 32'd0);
    check("st1_md_kept", done_md, 32'hDEADBEEF);

    // Read back the stored word.
    exp_q.push_back(32'h12345678);
    access_a(1'b1, 1'b0, 32'd1036, 32'd0);
    check("ld2_lat", 32'(lg_n), 32'd7);
    sb_check("ld2_data", done_md);

    // Load and store together: the store wins, mem_data is unchanged.
    access_a(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
    check("both_lat", 32'(lg_n), 32'd7);
    check_phase("both_lo", 1, 18'd8, 1'b0, 1'b1, 16'hF00D);
    check_phase("both_hi", 4, 18'd9, 1'b0, 1'b1, 16'hCAFE);
    check("both_md_kept", done_md, 32'h12345678);
    exp_q.push_back(32'hCAFEF00D);
    access_a(1'b1, 1'b0, 32'd1040, 32'd0);
    sb_check("ld3_data", done_md);

    // The low two address bits are ignored.
    exp_q.push_back(32'hDEADBEEF);
    access_a(1'b1, 1'b0, 32'd1035, 32'd0);
    check_phase("ld4_lo", 1, 18'd4, 1'b1, 1'b0, 16'h0);
    check_phase("ld4_hi", 4, 18'd5, 1'b1, 1'b0, 16'h0);
    sb_check("ld4_data", done_md);

    // Asynchronous reset while in RD_HI.
    a_r = 1'b1; a_alu = 32'd1036;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_state", 32'(a_state), 32'd2);
    rst = 1'b0; a_r = 1'b0;
    #1;
    check("mid_rst_state", 32'(a_state), 32'd0);
    check("mid_rst_ready", 32'(a_ready), 32'd1);
    check("mid_rst_we_n", 32'(a_we_n), 32'd1);
    check("mid_rst_oe", 32'(a_oe), 32'd0);
    check("mid_rst_md", a_md, 32'd0);
    check("mid_rst_addr", 32'(a_addr), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    exp_q.push_back(32'h12345678);
    access_a(1'b1, 1'b0, 32'd1036, 32'd0);
    check("post_rst_lat", 32'(lg_n), 32'd7);
    sb_check("post_rst_data", done_md);

    // WAIT_CYCLES=1: two back-to-back loads, request held across both.
    exp_q.push_back(32'h22221111);
    exp_q.push_back(32'h44443333);
    b_r = 1'b1; b_alu = 32'd1024;
    st_b4 = 3'd7;
    #1;
    for (int i = 0; i < 8; i++) begin
      rdy_b[i] = b_ready;
      if (i == 4) st_b4 = b_state;
      if (i == 3) begin
        sb_check("b2b_ld1_data", b_md);
        b_alu = 32'd1028;
      end
      if (i == 7) begin
        sb_check("b2b_ld2_data", b_md);
        b_r = 1'b0;
      end else begin
        @(posedge clk); #3;
      end
    end
    check("b2b_ready_pattern", 32'(rdy_b), 32'h88);
    check("b2b_gap_state", 32'(st_b4), 32'd0);
    check("b2b_we_n", 32'(b_we_n), 32'd1);
    @(posedge clk); #3;
    check("b2b_after_ready", 32'(b_ready), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- Memory-stage data-memory controller between the EX/MEM pipeline register and the MEM/WB register.
- Converts one 32-bit load/store into two 16-bit accesses on an external asynchronous SRAM.
- Returns load data as mem_data (drives Mem_Data_in of the MEM/WB register).
- Deasserts ready while busy; pipeline freeze = ~ready.

Parameters:
WAIT_CYCLES, 3, clock cycles per 16-bit SRAM access phase (must be >= 1)
BASE_ADDR, 1024, byte address that maps to SRAM word 0

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
Mem_R_EN  input  1  load request from EX/MEM register
Mem_W_EN  input  1  store request from EX/MEM register
ALU_res  input  32  byte address of access
Val_Rm  input  32  store data
mem_data  output  32  load result, registered
ready  output  1  1 = no access in progress, pipeline may advance
SRAM_ADDR  output  18  SRAM half-word address
SRAM_DQ  inout  16  SRAM data bus
SRAM_WE_N  output  1  SRAM write enable, active-low

Behaviour:
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Counter cnt, width max(1,$clog2(WAIT_CYCLES)), counts phase cycles 0..WAIT_CYCLES-1.

Reset (rst=0, any time including mid-access):
- state=IDLE, cnt=0, mem_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
- Any in-flight access is abandoned.

ready (combinational):
- ready = (state==IDLE && !Mem_R_EN && !Mem_W_EN) || state==DONE.
- ready falls in the same cycle a request appears.

Request accept (in IDLE):
- Mem_W_EN=1 → latch word index w = (ALU_res - BASE_ADDR)[18:2] and Val_Rm, go to WR_LO.
- Else if Mem_R_EN=1 → latch w, go to RD_LO.
- Both asserted: treated as a store; mem_data unchanged.
- Low 2 address bits are ignored; all accesses are word-aligned.

Half-word mapping:
- LO phase: SRAM_ADDR = {w,1'b0}, data half [15:0].
- HI phase: SRAM_ADDR = {w,1'b1}, data half [31:16].

Each phase (RD_LO, RD_HI, WR_LO, WR_HI):
- Lasts exactly WAIT_CYCLES cycles; cnt resets to 0 on phase entry.
- Advance LO→HI when cnt==WAIT_CYCLES-1; HI→DONE likewise.

Read phases:
- SRAM_WE_N=1, SRAM_DQ=Z.
- On the last cycle of RD_LO, capture SRAM_DQ into mem_data[15:0]; RD_HI likewise into [31:16].

Write phases:
- SRAM_WE_N=0, SRAM_DQ driven with the latched half, address stable for the whole phase.
- SRAM_WE_N returns to 1 in DONE.

DONE:
- One cycle, ready=1 (pipeline advances on this edge), then IDLE unconditionally.
- A new request in the following IDLE cycle is accepted normally, so back-to-back accesses are separated by one IDLE cycle.

Latency and idle outputs:
- Load or store: ready low for 1+2*WAIT_CYCLES cycles, high in the next cycle (DONE).
- mem_data holds its last value until the next load completes.
- Outside write phases SRAM_DQ is always Z; outside any phase SRAM_ADDR holds its last value.

Test Plan:
- Load, WAIT_CYCLES=3, ALU_res=1024+8, SRAM half-words 4=0xBEEF, 5=0xDEAD → ready low 7 cycles, DONE in 8th cycle, mem_data=0xDEADBEEF, SRAM_ADDR 4 then 5, SRAM_WE_N stays 1.
- Store ALU_res=1024+12, Val_Rm=0x12345678 → SRAM_ADDR=6 with DQ=0x5678 and WE_N=0 for 3 cycles, then ADDR=7 with DQ=0x1234 for 3 cycles, WE_N=1 in DONE; later load of the same address returns 0x12345678.
- Both Mem_R_EN and Mem_W_EN high → write sequence occurs, mem_data keeps its previous value.
- rst=0 asserted during RD_HI → immediately state IDLE, ready=1 (no request), SRAM_DQ=Z, SRAM_WE_N=1, mem_data=0; after release a fresh load completes normally.
- No request for 20 cycles → ready constantly 1, SRAM_WE_N=1, SRAM_DQ=Z.
- WAIT_CYCLES=1 build, back-to-back loads → ready pattern 0,0,0,1 per load, one IDLE (ready=0, request present) between DONE cycles, correct data each time.
